// File: rtl/score_render.sv
// Two-stage score glyph renderer: maps raster (x,y) to a "score lit" bit for the
// player and enemy digits, with per-frame score latching and change-blink.
module score_render #(
  parameter int X_POS_W      = 10,
  parameter int Y_POS_W      = 10,
  parameter int M_SCORE_W    = 4,
  parameter int SCALE        = 10,
  parameter int PS_X         = 520,
  parameter int PS_Y         = 50,
  parameter int ES_X         = 120,
  parameter int ES_Y         = 50,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [X_POS_W-1:0]   x_pos_i,
  input  logic [Y_POS_W-1:0]   y_pos_i,
  input  logic                 visible_i,
  input  logic                 frame_start_i,
  input  logic [M_SCORE_W-1:0] p_score_i,
  input  logic [M_SCORE_W-1:0] e_score_i,
  output logic                 pixel_o
);

  localparam int XW1 = X_POS_W + 1;
  localparam int YW1 = Y_POS_W + 1;

  localparam logic [X_POS_W:0] L_PS_X = XW1'(PS_X);
  localparam logic [X_POS_W:0] L_ES_X = XW1'(ES_X);
  localparam logic [Y_POS_W:0] L_PS_Y = YW1'(PS_Y);
  localparam logic [Y_POS_W:0] L_ES_Y = YW1'(ES_Y);
  localparam logic [X_POS_W:0] L_SX1  = XW1'(SCALE);
  localparam logic [X_POS_W:0] L_SX2  = XW1'(2 * SCALE);
  localparam logic [X_POS_W:0] L_W3   = XW1'(3 * SCALE);
  localparam logic [Y_POS_W:0] L_SY1  = YW1'(SCALE);
  localparam logic [Y_POS_W:0] L_SY2  = YW1'(2 * SCALE);
  localparam logic [Y_POS_W:0] L_SY3  = YW1'(3 * SCALE);
  localparam logic [Y_POS_W:0] L_SY4  = YW1'(4 * SCALE);
  localparam logic [Y_POS_W:0] L_H5   = YW1'(5 * SCALE);
  localparam logic [5:0]       L_BLINK = 6'(BLINK_FRAMES);

  function automatic logic [1:0] col_of(input logic [X_POS_W:0] d);
    logic [1:0] c;
    if (d < L_SX1)      c = 2'd0;
    else if (d < L_SX2) c = 2'd1;
    else                c = 2'd2;
    return c;
  endfunction

  function automatic logic [2:0] row_of(input logic [Y_POS_W:0] d);
    logic [2:0] r;
    if (d < L_SY1)      r = 3'd0;
    else if (d < L_SY2) r = 3'd1;
    else if (d < L_SY3) r = 3'd2;
    else if (d < L_SY4) r = 3'd3;
    else                r = 3'd4;
    return r;
  endfunction

  // Glyph bitmap: bit 14 is top-left, bit 0 bottom-right; values 10..15 are blank.
  function automatic logic glyph_bit(input logic [M_SCORE_W-1:0] val,
                                     input logic [2:0] row, input logic [1:0] col);
    logic [14:0] g;
    logic [3:0]  idx;
    case (val)
      M_SCORE_W'(0): g = 15'b111_101_101_101_111;
      M_SCORE_W'(1): g = 15'b010_010_010_010_010;
      M_SCORE_W'(2): g = 15'b111_001_111_100_111;
      M_SCORE_W'(3): g = 15'b111_001_111_001_111;
      M_SCORE_W'(4): g = 15'b101_101_111_001_001;
      M_SCORE_W'(5): g = 15'b111_100_111_001_111;
      M_SCORE_W'(6): g = 15'b111_100_111_101_111;
      M_SCORE_W'(7): g = 15'b111_001_001_001_001;
      M_SCORE_W'(8): g = 15'b111_101_111_101_111;
      M_SCORE_W'(9): g = 15'b111_101_111_001_111;
      default:       g = 15'd0;
    endcase
    idx = ({1'b0, row} * 4'd3) + {2'b00, col};
    return g[4'd14 - idx];
  endfunction

  logic [M_SCORE_W-1:0] r_p_lat, r_e_lat;
  logic [5:0]           r_p_blink, r_e_blink;

  logic [X_POS_W:0] w_p_dx, w_e_dx;
  logic [Y_POS_W:0] w_p_dy, w_e_dy;
  logic             w_p_hit, w_e_hit, w_p_hid, w_e_hid;

  logic                 r_p_hit, r_e_hit, r_p_hid, r_e_hid;
  logic [1:0]           r_p_col, r_e_col;
  logic [2:0]           r_p_row, r_e_row;
  logic [M_SCORE_W-1:0] r_p_val, r_e_val;
  logic                 r_pixel;

  // One bit wider than the position so a raster left of / above a box reads negative.
  always_comb begin
    w_p_dx  = {1'b0, x_pos_i} - L_PS_X;
    w_p_dy  = {1'b0, y_pos_i} - L_PS_Y;
    w_e_dx  = {1'b0, x_pos_i} - L_ES_X;
    w_e_dy  = {1'b0, y_pos_i} - L_ES_Y;
    w_p_hit = visible_i && !w_p_dx[X_POS_W] && (w_p_dx < L_W3) &&
              !w_p_dy[Y_POS_W] && (w_p_dy < L_H5);
    w_e_hit = visible_i && !w_e_dx[X_POS_W] && (w_e_dx < L_W3) &&
              !w_e_dy[Y_POS_W] && (w_e_dy < L_H5);
    w_p_hid = (r_p_blink != 6'd0) && r_p_blink[3];
    w_e_hid = (r_e_blink != 6'd0) && r_e_blink[3];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_p_lat   <= '0;
      r_e_lat   <= '0;
      r_p_blink <= 6'd0;
      r_e_blink <= 6'd0;
    end else if (frame_start_i) begin
      r_p_lat <= p_score_i;
      r_e_lat <= e_score_i;
      if (p_score_i != r_p_lat)  r_p_blink <= L_BLINK;
      else if (r_p_blink != 6'd0) r_p_blink <= r_p_blink - 6'd1;
      else                        r_p_blink <= r_p_blink;
      if (e_score_i != r_e_lat)  r_e_blink <= L_BLINK;
      else if (r_e_blink != 6'd0) r_e_blink <= r_e_blink - 6'd1;
      else                        r_e_blink <= r_e_blink;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_p_hit <= 1'b0;
      r_e_hit <= 1'b0;
      r_p_hid <= 1'b0;
      r_e_hid <= 1'b0;
      r_p_col <= 2'd0;
      r_e_col <= 2'd0;
      r_p_row <= 3'd0;
      r_e_row <= 3'd0;
      r_p_val <= '0;
      r_e_val <= '0;
    end else begin
      r_p_hit <= w_p_hit;
      r_e_hit <= w_e_hit;
      r_p_hid <= w_p_hid;
      r_e_hid <= w_e_hid;
      r_p_col <= col_of(w_p_dx);
      r_e_col <= col_of(w_e_dx);
      r_p_row <= row_of(w_p_dy);
      r_e_row <= row_of(w_e_dy);
      r_p_val <= r_p_lat;
      r_e_val <= r_e_lat;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pixel <= 1'b0;
    end else begin
      r_pixel <= (r_p_hit && !r_p_hid && glyph_bit(r_p_val, r_p_row, r_p_col)) ||
                 (r_e_hit && !r_e_hid && glyph_bit(r_e_val, r_e_row, r_e_col));
    end
  end

  assign pixel_o = r_pixel;

endmodule

// File: tb/tb_score_render.sv
// Self-checking bench for score_render: vector table plus scoreboard queue that
// pairs each driven pixel with the output two cycles later.
module tb_score_render;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [9:0] x_pos, y_pos;
  logic       visible, frame_start;
  logic [3:0] p_score, e_score;
  logic       pixel;

  score_render dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .x_pos_i      (x_pos),
    .y_pos_i      (y_pos),
    .visible_i    (visible),
    .frame_start_i(frame_start),
    .p_score_i    (p_score),
    .e_score_i    (e_score),
    .pixel_o      (pixel)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit    exp;
    bit    chk;
    int    x;
    int    y;
    string tag;
  } sb_t;

  typedef struct {
    int x;
    int y;
    bit vis;
    bit exp;
  } vec_t;

  sb_t  sbq[$];
  vec_t vt[13];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input bit act, input bit exp, input int x, input int y);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: pixel_o=%0b expected %0b at x=%0d y=%0d", tag, act, exp, x, y);
    end
  endtask

  task automatic drive(input int x, input int y, input bit vis, input bit fs,
                       input bit exp, input bit chk, input string tag);
    sb_t s;
    x_pos       = 10'(x);
    y_pos       = 10'(y);
    visible     = vis;
    frame_start = fs;
    sbq.push_back('{exp, chk, x, y, tag});
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    if (sbq.size() == 2) begin
      s = sbq.pop_front();
      if (s.chk) check(s.tag, pixel, s.exp, s.x, s.y);
    end
  endtask

  task automatic flush();
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  function automatic bit blink_shown(input int n);
    return !((n >= 1 && n <= 8) || (n >= 17 && n <= 24));
  endfunction

  initial begin
    vt[0]  = '{520,  50, 1'b1, 1'b1};
    vt[1]  = '{530,  70, 1'b1, 1'b0};
    vt[2]  = '{549,  99, 1'b1, 1'b1};
    vt[3]  = '{550,  50, 1'b1, 1'b0};
    vt[4]  = '{519,  50, 1'b1, 1'b0};
    vt[5]  = '{520, 100, 1'b1, 1'b0};
    vt[6]  = '{130,  60, 1'b1, 1'b1};
    vt[7]  = '{120,  60, 1'b1, 1'b0};
    vt[8]  = '{520,  50, 1'b0, 1'b0};
    vt[9]  = '{521,  75, 1'b1, 1'b1};
    vt[10] = '{535,  65, 1'b1, 1'b0};
    vt[11] = '{0,     0, 1'b1, 1'b0};
    vt[12] = '{1023, 1023, 1'b1, 1'b0};

    rst_ni = 1'b0; x_pos = '0; y_pos = '0; visible = 1'b0; frame_start = 1'b0;
    p_score = 4'd0; e_score = 4'd1;
    repeat (3) @(posedge clk);
    #1;
    check("reset", pixel, 1'b0, 0, 0);
    rst_ni = 1'b1;

    // First frame: player 0, enemy 1 (enemy counter loads 32 -> shown).
    drive(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, "fs");
    foreach (vt[i]) drive(vt[i].x, vt[i].y, vt[i].vis, 1'b0, vt[i].exp, 1'b1, "table");
    flush();

    for (int x = 100; x < 560; x++)
      drive(x, 50, 1'b1, 1'b0, ((x >= 520 && x < 550) || (x >= 130 && x < 140)), 1'b1, "stream");
    flush();

    // Mid-frame score change is invisible until the next frame start.
    p_score = 4'd1;
    drive(520, 50, 1'b1, 1'b0, 1'b1, 1'b1, "midframe_old");
    drive(520, 50, 1'b1, 1'b1, 1'b1, 1'b1, "fs_cycle_old");
    drive(520, 50, 1'b1, 1'b0, 1'b0, 1'b1, "new_digit_gap");
    drive(530, 50, 1'b1, 1'b0, 1'b1, 1'b1, "new_digit_lit");
    flush();

    // Settle enemy at 3, then blink after 3 -> 4.
    e_score = 4'd3;
    repeat (40) drive(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, "fs");
    drive(120, 50, 1'b1, 1'b0, 1'b1, 1'b1, "steady3");
    e_score = 4'd4;
    for (int n = 0; n < 35; n++) begin
      drive(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, "fs");
      drive(120, 50, 1'b1, 1'b0, blink_shown(n), 1'b1, "blink");
    end
    flush();

    // Change mid-blink restarts the sequence.
    e_score = 4'd6;
    for (int n = 0; n < 13; n++) begin
      drive(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, "fs");
      drive(120, 50, 1'b1, 1'b0, blink_shown(n), 1'b1, "blink6");
    end
    e_score = 4'd7;
    for (int n = 0; n < 11; n++) begin
      drive(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, "fs");
      drive(120, 50, 1'b1, 1'b0, blink_shown(n), 1'b1, "reload7");
    end
    flush();

    // Blank digit value.
    p_score = 4'd12;
    drive(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, "fs");
    drive(520, 50, 1'b1, 1'b0, 1'b0, 1'b1, "blank");
    drive(530, 60, 1'b1, 1'b0, 1'b0, 1'b1, "blank");
    drive(549, 99, 1'b1, 1'b0, 1'b0, 1'b1, "blank");
    drive(535, 75, 1'b1, 1'b0, 1'b0, 1'b1, "blank");
    flush();

    // Asynchronous reset mid-line.
    p_score = 4'd0;
    drive(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, "fs");
    drive(520, 50, 1'b1, 1'b0, 1'b1, 1'b1, "pre_rst");
    drive(520, 50, 1'b1, 1'b0, 1'b1, 1'b1, "pre_rst");
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst", pixel, 1'b0, 520, 50);
    sbq.delete();
    @(negedge clk);
    rst_ni = 1'b1;

    // After release digits show 0 until the next frame start.
    p_score = 4'd7;
    drive(520, 70, 1'b1, 1'b0, 1'b1, 1'b1, "post_rst_zero");
    drive(120, 70, 1'b1, 1'b0, 1'b1, 1'b1, "post_rst_zero_e");
    drive(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, "fs");
    drive(520, 70, 1'b1, 1'b0, 1'b0, 1'b1, "post_rst_seven");
    drive(540, 70, 1'b1, 1'b0, 1'b1, 1'b1, "post_rst_seven");
    flush();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
